// File: rtl/vec_pkg.sv
// Shared constants and types for the vector memory-stage sequencer.
package vec_pkg;

   localparam int unsigned LANES  = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LANE_W = $clog2(LANES);

   typedef logic [LANES-1:0][DATA_W-1:0] vec_t;
   typedef logic [LANE_W-1:0]            lane_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

endpackage

// File: rtl/vec_addr_gen.sv
// Lane address generator: latches base (and stride when VEC_MEM_STRIDE_EN is defined)
// and walks base + lane*stride incrementally, wrapping modulo 2^ADDR_W.
module vec_addr_gen
   import vec_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
`ifdef VEC_MEM_STRIDE_EN
   input  logic [ADDR_W-1:0] stride_i,
`endif
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] stride;

`ifdef VEC_MEM_STRIDE_EN
   logic [ADDR_W-1:0] stride_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stride_q <= '0;
      end else if (load_i) begin
         stride_q <= stride_i;
      end
   end

   assign stride = stride_q;
`else
   assign stride = ADDR_W'(4);
`endif

   // Accumulating the stride avoids a lane*stride multiplier.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
      end else if (load_i) begin
         addr_q <= base_i;
      end else if (step_i) begin
         addr_q <= addr_q + stride;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: serialises 16 lanes onto a 32-bit req/ack memory port.
// Define VEC_MEM_STRIDE_EN to add the StrideM input (signed byte stride per lane).
module vec_mem_seq
   import vec_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              MemReqM,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] AddrM,
`ifdef VEC_MEM_STRIDE_EN
   input  logic [ADDR_W-1:0] StrideM,
`endif
   input  vec_t              WriteDataM,
   output vec_t              ReadDataM,
   output logic              StallM,
   output logic              DoneM,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   state_e            state_q;
   lane_t             lane_q;
   logic              we_q;
   vec_t              wdata_q;
   vec_t              rdata_q;
   logic              accept;
   logic              busy;
   logic              step;
   logic              last;
   logic [ADDR_W-1:0] lane_addr;

   assign accept = (state_q == IDLE) && MemReqM;
   assign busy   = (state_q == BUSY);
   assign step   = busy && mem_ack;
   assign last   = (lane_q == lane_t'(LANES - 1));

   vec_addr_gen u_addr_gen (
      .clk_i   (CLK),
      .rst_i   (RST),
      .load_i  (accept),
      .step_i  (step),
      .base_i  (AddrM),
`ifdef VEC_MEM_STRIDE_EN
      .stride_i(StrideM),
`endif
      .addr_o  (lane_addr)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         lane_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (MemReqM) begin
                  we_q    <= MemWriteM;
                  wdata_q <= WriteDataM;
                  lane_q  <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  if (!we_q) begin
                     rdata_q[lane_q] <= mem_rdata;
                  end
                  if (last) begin
                     state_q <= DONE;
                  end else begin
                     lane_q <= lane_q + lane_t'(1);
                  end
               end
            end
            // MemReqM here still belongs to the finishing instruction.
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory outputs decode straight from registered state, so they only move on edges.
   assign mem_req   = busy;
   assign mem_we    = busy && we_q;
   assign mem_addr  = busy ? lane_addr : '0;
   assign mem_wdata = busy ? wdata_q[lane_q] : '0;
   assign DoneM     = (state_q == DONE);
   assign StallM    = busy || accept;
   assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Randomised directed bench for vec_mem_seq against a transaction-level memory model.
module tb_vec_mem_seq;
   import vec_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        MemReqM;
   logic        MemWriteM;
   logic [31:0] AddrM;
   logic [31:0] stride_v = 32'd4;
   vec_t        WriteDataM;
   vec_t        ReadDataM;
   logic        StallM;
   logic        DoneM;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int          vectors = 0;
   int          miscompares = 0;
   vec_t        exp_rd = '0;
   logic [31:0] mem [logic [31:0]];

   always #5 CLK = ~CLK;

   vec_mem_seq dut (
      .CLK       (CLK),
      .RST       (RST),
      .MemReqM   (MemReqM),
      .MemWriteM (MemWriteM),
      .AddrM     (AddrM),
`ifdef VEC_MEM_STRIDE_EN
      .StrideM   (stride_v),
`endif
      .WriteDataM(WriteDataM),
      .ReadDataM (ReadDataM),
      .StallM    (StallM),
      .DoneM     (DoneM),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Unwritten words read back as their own address.
   function automatic logic [31:0] rd_model(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : a;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < 16; i++) v[i] = $urandom;
      return v;
   endfunction

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge CLK);
         MemReqM = 1'b0;
         mem_ack = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         #1;
         chk("idle_req", mem_req, 1'b0);
         chk("idle_stall", StallM, 1'b0);
         chk("idle_done", DoneM, 1'b0);
         chk("idle_rdata", ReadDataM, exp_rd);
      end
   endtask

   task automatic run_op(input bit we, input logic [31:0] base, input logic [31:0] stride,
                         input vec_t wd, input int wmin, input int wmax, input int abort_lane);
      logic [31:0] a;
      int          w;
      int          stall_seen;
      int          exp_stalls;
      @(negedge CLK);
      MemReqM = 1'b1;
      MemWriteM = we;
      AddrM = base;
      stride_v = stride;
      WriteDataM = wd;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      #1;
      chk("accept_stall", StallM, 1'b1);
      chk("accept_req", mem_req, 1'b0);
      chk("accept_done", DoneM, 1'b0);
      stall_seen = int'(StallM);
      exp_stalls = 1;
      for (int i = 0; i < 16; i++) begin
         a = base + 32'(i) * stride;
         w = $urandom_range(wmax, wmin);
         for (int k = 0; k <= w; k++) begin
            @(negedge CLK);
            if (i == abort_lane) begin
               RST = 1'b1;
               MemReqM = 1'b0;
               mem_ack = 1'b0;
               exp_rd = '0;
               #1;
               chk("rst_req", mem_req, 1'b0);
               chk("rst_stall", StallM, 1'b0);
               chk("rst_rdata", ReadDataM, exp_rd);
               @(negedge CLK);
               RST = 1'b0;
               #1;
               chk("rst_rel_req", mem_req, 1'b0);
               chk("rst_rel_addr", mem_addr, 32'h0);
               return;
            end
            MemReqM = 1'b1;
            MemWriteM = 1'($urandom_range(0, 1));
            AddrM = $urandom;
            stride_v = $urandom;
            WriteDataM = rand_vec();
            mem_ack = (k == w);
            mem_rdata = (k == w) ? rd_model(a) : $urandom;
            #1;
            chk("busy_req", mem_req, 1'b1);
            chk("busy_we", mem_we, we);
            chk("busy_addr", mem_addr, a);
            chk("busy_wdata", mem_wdata, wd[i]);
            chk("busy_done", DoneM, 1'b0);
            chk("busy_rdata", ReadDataM, exp_rd);
            stall_seen += int'(StallM);
            exp_stalls++;
            if (k == w) begin
               if (we) mem[a] = wd[i];
               else exp_rd[i] = rd_model(a);
            end
         end
      end
      @(negedge CLK);
      MemReqM = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      chk("done_pulse", DoneM, 1'b1);
      chk("done_stall", StallM, 1'b0);
      chk("done_req", mem_req, 1'b0);
      chk("done_we", mem_we, 1'b0);
      chk("done_rdata", ReadDataM, exp_rd);
      chk("stall_len", 32'(stall_seen), 32'(exp_stalls));
   endtask

   initial begin
      vec_t v;
      RST = 1'b1;
      MemReqM = 1'b0;
      MemWriteM = 1'b0;
      AddrM = '0;
      WriteDataM = '0;
      mem_rdata = '0;
      mem_ack = 1'b0;
      @(negedge CLK);
      #1;
      chk("reset_rdata", ReadDataM, vec_t'('0));
      chk("reset_req", mem_req, 1'b0);
      chk("reset_we", mem_we, 1'b0);
      chk("reset_addr", mem_addr, 32'h0);
      chk("reset_wdata", mem_wdata, 32'h0);
      chk("reset_done", DoneM, 1'b0);
      chk("reset_stall", StallM, 1'b0);
      MemReqM = 1'b1;
      #1;
      chk("reset_stall_comb", StallM, 1'b1);
      @(negedge CLK);
      RST = 1'b0;
      MemReqM = 1'b0;
      idle(2);

      // Unit-stride load with zero-wait memory, then a store with two wait cycles per word.
      run_op(1'b0, 32'h100, 32'd4, rand_vec(), 0, 0, -1);
      idle(1);
      for (int i = 0; i < 16; i++) v[i] = 32'hA000 + 32'(i);
      run_op(1'b1, 32'h200, 32'd4, v, 2, 2, -1);
      idle(1);

      // Address wrap past 2^32.
      run_op(1'b0, 32'hFFFF_FFF8, 32'd4, rand_vec(), 0, 1, -1);
      idle(1);

      // Back-to-back: load then store with MemReqM held through DONE.
      run_op(1'b0, 32'h200, 32'd4, rand_vec(), 0, 2, -1);
      run_op(1'b1, 32'h240, 32'd4, rand_vec(), 0, 1, -1);
      idle(1);

      // Abort at lane 7, then a clean load.
      run_op(1'b0, 32'h300, 32'd4, rand_vec(), 0, 1, 7);
      idle(1);
      run_op(1'b0, 32'h240, 32'd4, rand_vec(), 0, 1, -1);
      idle(1);

`ifdef VEC_MEM_STRIDE_EN
      run_op(1'b0, 32'h400, 32'hFFFF_FFF8, rand_vec(), 0, 1, -1);
      idle(1);
      run_op(1'b1, 32'h400, 32'h0, rand_vec(), 0, 1, -1);
      idle(1);
`endif

      for (int n = 0; n < 6; n++) begin
         run_op(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 16)) * 32'd4,
                32'd4, rand_vec(), 0, 3, -1);
         if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
